// File: rtl/powermanager_pkg.sv
// Purpose: shared definitions for the powermanager AXI4-Lite slave and its rail sequencer.
// Latency: none (types, constants and a helper function only).
// Backpressure: not applicable.
// Contents: register byte offsets, sequencer state enum, AXI response codes, WSTRB lane-mask helper.
package powermanager_pkg;

    // Register byte offsets inside the 32-byte window
    localparam logic [4:0] PM_CTRL_OFS    = 5'h00;
    localparam logic [4:0] PM_MASK_OFS    = 5'h04;
    localparam logic [4:0] PM_DELAY_OFS   = 5'h08;
    localparam logic [4:0] PM_SCRATCH_OFS = 5'h0C;
    localparam logic [4:0] PM_STATUS_OFS  = 5'h10;

    // Encodings are visible software-side through STATUS[1:0]
    typedef enum logic [1:0] {
        PM_IDLE = 2'd0,
        PM_UP   = 2'd1,
        PM_ON   = 2'd2,
        PM_DOWN = 2'd3
    } pm_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] pm_strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/pm_rail_sequencer.sv
// Purpose: rail power-sequencing FSM; rails turn on one per step ascending and off one per step descending.
// Latency: one step every delay+1 cycles after entering UP/DOWN; pwr_en is registered.
// Backpressure: none; req is a level, mask/delay are sampled only on entry to UP.
// Ports: clk, rst_n (async active-low); req, mask[N_RAILS-1:0], delay[15:0] in; state, pwr_en[N_RAILS-1:0] out.
module pm_rail_sequencer
    import powermanager_pkg::*;
#(
    parameter int N_RAILS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [N_RAILS-1:0] mask,
    input  logic [15:0]        delay,
    output pm_state_t          state,
    output logic [N_RAILS-1:0] pwr_en
);

    localparam int IDX_W = (N_RAILS > 1) ? $clog2(N_RAILS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_RAILS - 1);

    pm_state_t          state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [15:0]        cnt, cnt_nxt;
    logic [15:0]        delay_l, delay_l_nxt;
    logic [N_RAILS-1:0] mask_l, mask_l_nxt;
    logic [N_RAILS-1:0] pwr_en_nxt;
    logic               step;

    // cnt runs 0..delay_l, so a step lasts delay_l+1 cycles; it is cleared on
    // every step, which keeps delay 0xFFFF from ever wrapping.
    assign step = (cnt == delay_l);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PM_IDLE;
            idx     <= '0;
            cnt     <= '0;
            delay_l <= '0;
            mask_l  <= '0;
            pwr_en  <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            delay_l <= delay_l_nxt;
            mask_l  <= mask_l_nxt;
            pwr_en  <= pwr_en_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        delay_l_nxt = delay_l;
        mask_l_nxt  = mask_l;
        pwr_en_nxt  = pwr_en;
        case (state)
            PM_IDLE: begin
                if (req) begin
                    state_nxt   = PM_UP;
                    mask_l_nxt  = mask;
                    delay_l_nxt = delay;
                    idx_nxt     = '0;
                    cnt_nxt     = '0;
                end
            end
            PM_UP: begin
                if (!req) begin
                    // idx names the next rail to handle, so the last rail
                    // already handled is idx-1; unwind from there.
                    state_nxt = PM_DOWN;
                    cnt_nxt   = '0;
                    idx_nxt   = (idx == '0) ? '0 : idx - 1'b1;
                end else if (step) begin
                    cnt_nxt         = '0;
                    pwr_en_nxt[idx] = mask_l[idx];
                    if (idx == IDX_LAST) begin
                        state_nxt = PM_ON;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PM_ON: begin
                if (!req) begin
                    state_nxt = PM_DOWN;
                    cnt_nxt   = '0;
                    idx_nxt   = IDX_LAST;
                end
            end
            PM_DOWN: begin
                // req is ignored here: a shutdown always completes to IDLE,
                // and IDLE re-enters UP if req is still set.
                if (step) begin
                    cnt_nxt         = '0;
                    pwr_en_nxt[idx] = 1'b0;
                    if (idx == '0) begin
                        state_nxt = PM_IDLE;
                    end else begin
                        idx_nxt = idx - 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = PM_IDLE;
        endcase
    end

endmodule

// File: rtl/powermanager_axil_slave.sv
// Purpose: AXI4-Lite register slave (CTRL, MASK, DELAY, SCRATCH, RO STATUS) driving the rail sequencer.
// Latency: write updates on the AW/W handshake edge, BVALID one cycle later; RDATA/RVALID one cycle after AR handshake.
// Backpressure: one write and one read outstanding; BVALID/RVALID hold until BREADY/RREADY, new AW/W or AR blocked meanwhile.
// Ports: S_AXI_* AXI4-Lite slave on S_AXI_ACLK / S_AXI_ARESETN (async active-low); pwr_en[N_RAILS-1:0] registered rail enables.
// Build option: define PM_WSTRB_EN to honour WSTRB byte lanes; otherwise every accepted write replaces all 32 bits.
module powermanager_axil_slave
    import powermanager_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int N_RAILS            = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [N_RAILS-1:0]              pwr_en
);

    logic        clk;
    logic        rst_n;
    logic        wr_rdy, bvalid, rd_rdy, rvalid;
    logic        aw_ok, wr_go, rd_go;
    logic [4:0]  waddr, raddr;
    logic [31:0] wr_bits;
    logic [31:0] ctrl_r, mask_r, delay_r, scratch_r;
    logic [31:0] status, rd_mux, rdata;
    pm_state_t   state;

    assign clk   = S_AXI_ACLK;
    assign rst_n = S_AXI_ARESETN;

    // Protection bits and the byte offset within a word carry no meaning here
    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};

    assign waddr = {S_AXI_AWADDR[4:2], 2'b00};
    assign raddr = {S_AXI_ARADDR[4:2], 2'b00};

`ifdef PM_WSTRB_EN
    assign wr_bits = pm_strb_mask(S_AXI_WSTRB);
`else
    assign wr_bits = '1;
`endif

    function automatic logic [31:0] wr_merge(input logic [31:0] old);
        return (old & ~wr_bits) | (S_AXI_WDATA & wr_bits);
    endfunction

    // AWREADY/WREADY are one shared pulse: raised only when both channels are
    // presented and no response is pending, dropped the following cycle.
    assign aw_ok = S_AXI_AWVALID && S_AXI_WVALID && !bvalid && !wr_rdy;
    assign wr_go = wr_rdy && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_go = rd_rdy && S_AXI_ARVALID;

    always_comb begin
        status                 = '0;
        status[1:0]            = state;
        status[8 +: N_RAILS]   = pwr_en;
    end

    always_comb begin
        rd_mux = '0;
        case (raddr)
            PM_CTRL_OFS:    rd_mux = ctrl_r;
            PM_MASK_OFS:    rd_mux = mask_r;
            PM_DELAY_OFS:   rd_mux = delay_r;
            PM_SCRATCH_OFS: rd_mux = scratch_r;
            PM_STATUS_OFS:  rd_mux = status;
            default:        rd_mux = '0;
        endcase
    end

    // Write channel and register file. A read on the same edge samples
    // rd_mux before these updates land, so it returns the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_rdy    <= 1'b0;
            bvalid    <= 1'b0;
            ctrl_r    <= '0;
            mask_r    <= '0;
            delay_r   <= '0;
            scratch_r <= '0;
        end else begin
            wr_rdy <= aw_ok;
            if (wr_go) begin
                bvalid <= 1'b1;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
            if (wr_go) begin
                case (waddr)
                    PM_CTRL_OFS:    ctrl_r    <= wr_merge(ctrl_r);
                    PM_MASK_OFS:    mask_r    <= wr_merge(mask_r);
                    PM_DELAY_OFS:   delay_r   <= wr_merge(delay_r);
                    PM_SCRATCH_OFS: scratch_r <= wr_merge(scratch_r);
                    default: ;  // STATUS and unmapped offsets drop the data
                endcase
            end
        end
    end

    // Read channel; RDATA only changes on an AR handshake so it stays stable
    // while RVALID waits for RREADY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_rdy <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rd_rdy <= S_AXI_ARVALID && !rvalid && !rd_rdy;
            if (rd_go) begin
                rdata  <= rd_mux;
                rvalid <= 1'b1;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = wr_rdy;
    assign S_AXI_WREADY  = wr_rdy;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_ARREADY = rd_rdy;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;

    pm_rail_sequencer #(
        .N_RAILS (N_RAILS)
    ) u_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (ctrl_r[0]),
        .mask   (mask_r[N_RAILS-1:0]),
        .delay  (delay_r[15:0]),
        .state  (state),
        .pwr_en (pwr_en)
    );

endmodule

// File: tb/tb_powermanager_axil_slave.sv
// Purpose: self-checking bench for powermanager_axil_slave (register map, sequencing, backpressure, reset).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: BREADY/RREADY are held low in dedicated scenarios.
module tb_powermanager_axil_slave;
    import powermanager_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [N-1:0] pwr_en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int hs_cyc   = 0;

    logic [31:0]  r_q[$];
    logic [1:0]   b_q[$];
    logic [N-1:0] p_q[$];
    int           g_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    powermanager_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (5),
        .N_RAILS            (N)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .pwr_en        (pwr_en)
    );

    // Full AW+W+B transaction; hs_cyc records the cycle of the handshake edge.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic [1:0] e;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        b_q.push_back(AXI_RESP_OKAY);
        n = 0;
        while (!(awready && wready) && n < 50) begin @(negedge clk); n++; end
        hs_cyc = cyc + 1;
        checks++;
        if (!(awready && wready)) begin
            failures++;
            $display("FAIL wr_accept addr=%h awready=%b wready=%b required 1", a, awready, wready);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        e = b_q.pop_front();
        checks++;
        if (bvalid !== 1'b1 || bresp !== e) begin
            failures++;
            $display("FAIL wr_resp addr=%h bvalid=%b bresp=%b required 1/%b", a, bvalid, bresp, e);
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    // AR+R transaction; with hold>0, RREADY stays low for hold cycles after RVALID.
    task automatic axi_read(input logic [4:0] a, input logic [31:0] exp, input int hold);
        int n;
        bit ok;
        logic [31:0] e, held;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        r_q.push_back(exp);
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (!arready) begin
            failures++;
            $display("FAIL rd_accept addr=%h arready=%b required 1", a, arready);
        end
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clk); n++; end
        e = r_q.pop_front();
        checks++;
        if (rvalid !== 1'b1 || rdata !== e || rresp !== AXI_RESP_OKAY) begin
            failures++;
            $display("FAIL rd_data addr=%h rvalid=%b rdata=%h rresp=%b required 1/%h/00", a, rvalid, rdata, rresp, e);
        end
        if (hold > 0) begin
            held = rdata; ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (rvalid !== 1'b1 || rdata !== held) ok = 1'b0;
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rd_hold addr=%h rvalid=%b rdata=%h required 1/%h", a, rvalid, rdata, held);
            end
        end
        rready = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_release addr=%h rvalid=%b required 0", a, rvalid);
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 || rresp !== 2'b00) begin
            failures++;
            $display("FAIL reset_axi rdy/vld=%b bresp=%b rresp=%b required 00000/00/00",
                     {awready, wready, arready, bvalid, rvalid}, bresp, rresp);
        end
        checks++;
        if (rdata !== 32'h0 || pwr_en !== '0) begin
            failures++;
            $display("FAIL reset_out rdata=%h pwr_en=%b required 0/0", rdata, pwr_en);
        end
        axi_read(PM_STATUS_OFS, 32'h0, 0);
        axi_read(PM_SCRATCH_OFS, 32'h0, 0);
    endtask

    task automatic test_regs();
        // CTRL goes first, so the sequencer latches MASK=0 and runs with no rails.
        axi_write(PM_CTRL_OFS,    32'h01, 4'hF);
        axi_write(PM_MASK_OFS,    32'h02, 4'hF);
        axi_write(PM_DELAY_OFS,   32'h03, 4'hF);
        axi_write(PM_SCRATCH_OFS, 32'h04, 4'hF);
        axi_read(PM_CTRL_OFS,    32'h01, 0);
        axi_read(PM_MASK_OFS,    32'h02, 0);
        axi_read(PM_DELAY_OFS,   32'h03, 0);
        axi_read(PM_SCRATCH_OFS, 32'h04, 0);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF);
        axi_write(5'h18, 32'hFFFF_FFFF, 4'hF);
        axi_write(PM_STATUS_OFS, 32'hFFFF_FFFF, 4'hF);
        axi_read(PM_CTRL_OFS, 32'h01, 0);
        axi_read(PM_MASK_OFS, 32'h02, 0);
        axi_read(5'h14, 32'h0, 0);
        axi_read(5'h18, 32'h0, 0);
        axi_read(5'h1C, 32'h0, 0);
        axi_read(PM_STATUS_OFS, 32'h0000_0002, 0);
        axi_write(PM_SCRATCH_OFS, 32'hDEAD_BEEF, 4'hF);
        axi_read(PM_SCRATCH_OFS, 32'hDEAD_BEEF, 0);
        axi_write(PM_CTRL_OFS, 32'h0, 4'hF);
        repeat (20) @(negedge clk);
        axi_read(PM_STATUS_OFS, 32'h0, 0);
    endtask

    task automatic test_power_up();
        int n, last, gap;
        logic [N-1:0] prev, e;
        axi_write(PM_MASK_OFS,  32'hF, 4'hF);
        axi_write(PM_DELAY_OFS, 32'h2, 4'hF);
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                p_q.push_back(4'b0001); p_q.push_back(4'b0011);
                p_q.push_back(4'b0111); p_q.push_back(4'b1111);
                axi_write(PM_CTRL_OFS, 32'h1, 4'hF);
            end else begin
                p_q.push_back(4'b0111); p_q.push_back(4'b0011);
                p_q.push_back(4'b0001); p_q.push_back(4'b0000);
                axi_write(PM_CTRL_OFS, 32'h0, 4'hF);
            end
            // one cycle to leave IDLE/ON, then 3 cycles per step
            last = hs_cyc; prev = pwr_en; gap = 4;
            while (p_q.size() > 0) begin
                e = p_q.pop_front();
                n = 0;
                while (pwr_en === prev && n < 100) begin @(negedge clk); n++; end
                checks++;
                if (pwr_en !== e || (cyc - last) != gap) begin
                    failures++;
                    $display("FAIL seq_step phase=%0d pwr_en=%b after %0d cycles required %b after %0d",
                             ph, pwr_en, cyc - last, e, gap);
                end
                prev = pwr_en; last = cyc; gap = 3;
            end
            axi_read(PM_STATUS_OFS, (ph == 0) ? 32'h0000_0F02 : 32'h0, 0);
        end
    endtask

    task automatic test_mask_abort();
        int n, last, ref0;
        logic [N-1:0] prev, e;
        // MASK=5, DELAY=0: a step per cycle, odd rails stay off
        axi_write(PM_MASK_OFS,  32'h5, 4'hF);
        axi_write(PM_DELAY_OFS, 32'h0, 4'hF);
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 0) begin
                p_q.push_back(4'b0001); g_q.push_back(2);
                p_q.push_back(4'b0101); g_q.push_back(2);
                axi_write(PM_CTRL_OFS, 32'h1, 4'hF);
            end else begin
                p_q.push_back(4'b0001); g_q.push_back(3);
                p_q.push_back(4'b0000); g_q.push_back(2);
                axi_write(PM_CTRL_OFS, 32'h0, 4'hF);
            end
            last = hs_cyc; prev = pwr_en;
            while (p_q.size() > 0) begin
                e = p_q.pop_front();
                n = 0;
                while (pwr_en === prev && n < 100) begin @(negedge clk); n++; end
                checks++;
                if (pwr_en !== e || (cyc - last) != g_q[0]) begin
                    failures++;
                    $display("FAIL mask_step phase=%0d pwr_en=%b after %0d cycles required %b after %0d",
                             ph, pwr_en, cyc - last, e, g_q[0]);
                end
                void'(g_q.pop_front());
                prev = pwr_en; last = cyc;
            end
            axi_read(PM_STATUS_OFS, (ph == 0) ? 32'h0000_0502 : 32'h0, 0);
        end
        // Abort mid-UP with DELAY=9 (10-cycle steps). MASK/DELAY rewritten
        // while UP must not alter the latched values.
        axi_write(PM_DELAY_OFS, 32'h9, 4'hF);
        axi_write(PM_CTRL_OFS,  32'h1, 4'hF);
        ref0 = hs_cyc;
        axi_write(PM_MASK_OFS,  32'h0, 4'hF);
        axi_write(PM_DELAY_OFS, 32'h0, 4'hF);
        p_q.push_back(4'b0001);
        n = 0;
        while (pwr_en === 4'b0000 && n < 100) begin @(negedge clk); n++; end
        e = p_q.pop_front();
        checks++;
        if (pwr_en !== e || (cyc - ref0) != 11) begin
            failures++;
            $display("FAIL abort_first pwr_en=%b after %0d cycles required %b after 11", pwr_en, cyc - ref0, e);
        end
        // step idx1 lands 10 cycles later; abort before idx2
        repeat (12) @(negedge clk);
        axi_write(PM_CTRL_OFS, 32'h0, 4'hF);
        ref0 = hs_cyc;
        // DOWN from idx1: 10 cycles for idx1, 10 more for idx0, plus entry cycle
        p_q.push_back(4'b0000);
        n = 0;
        while (pwr_en === 4'b0001 && n < 200) begin @(negedge clk); n++; end
        e = p_q.pop_front();
        checks++;
        if (pwr_en !== e || (cyc - ref0) != 21) begin
            failures++;
            $display("FAIL abort_down pwr_en=%b after %0d cycles required %b after 21", pwr_en, cyc - ref0, e);
        end
        axi_read(PM_STATUS_OFS, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        int n;
        bit ok;
        logic [1:0] e;
        @(negedge clk);
        awaddr = PM_SCRATCH_OFS; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        b_q.push_back(AXI_RESP_OKAY);
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        wdata = 32'h66;  // second write presented while B is still pending
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        e = b_q.pop_front();
        checks++;
        if (!ok || bresp !== e) begin
            failures++;
            $display("FAIL b_hold bvalid=%b awready=%b bresp=%b required 1/0/%b", bvalid, awready, bresp, e);
        end
        bready = 1'b1;
        b_q.push_back(AXI_RESP_OKAY);
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        e = b_q.pop_front();
        checks++;
        if (bvalid !== 1'b1 || bresp !== e) begin
            failures++;
            $display("FAIL b_second bvalid=%b bresp=%b required 1/%b", bvalid, bresp, e);
        end
        @(negedge clk);
        bready = 1'b0;
        axi_read(PM_SCRATCH_OFS, 32'h66, 10);
    endtask

    task automatic test_wstrb();
        axi_write(PM_SCRATCH_OFS, 32'h1122_3344, 4'hF);
        axi_write(PM_SCRATCH_OFS, 32'hAABB_CCDD, 4'b0010);
`ifdef PM_WSTRB_EN
        axi_read(PM_SCRATCH_OFS, 32'h1122_CC44, 0);
`else
        axi_read(PM_SCRATCH_OFS, 32'hAABB_CCDD, 0);
`endif
    endtask

    task automatic test_reset_mid();
        int n;
        axi_write(PM_MASK_OFS,  32'hF,  4'hF);
        axi_write(PM_DELAY_OFS, 32'd20, 4'hF);
        axi_write(PM_CTRL_OFS,  32'h1,  4'hF);
        n = 0;
        while (pwr_en === '0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (pwr_en !== 4'b0001) begin
            failures++;
            $display("FAIL mid_up pwr_en=%b required 0001", pwr_en);
        end
        @(negedge clk);
        awaddr = PM_SCRATCH_OFS; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || pwr_en !== '0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL async_reset rdy/vld=%b pwr_en=%b rdata=%h required 00000/0/0",
                     {awready, wready, arready, bvalid, rvalid}, pwr_en, rdata);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        axi_read(PM_CTRL_OFS,    32'h0, 0);
        axi_read(PM_MASK_OFS,    32'h0, 0);
        axi_read(PM_DELAY_OFS,   32'h0, 0);
        axi_read(PM_SCRATCH_OFS, 32'h0, 0);
        axi_read(PM_STATUS_OFS,  32'h0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_regs();
        test_power_up();
        test_mask_abort();
        test_backpressure();
        test_wstrb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
